// File: rtl/drf_port_pkg.sv
// Shared command codes and STATUS nibble layout for the DRF CPU port.
// Also imported by CPU-side test programs.
package drf_port_pkg;

    typedef enum logic [3:0] {
        CMD_IDLE      = 4'h0,
        CMD_RD_HI     = 4'h1,
        CMD_RD_LO_POP = 4'h2,
        CMD_STATUS    = 4'h3,
        CMD_CLR_ERR   = 4'hF
    } drf_cmd_e;

    localparam int STAT_EMPTY_BIT = 3;
    localparam int STAT_FULL_BIT  = 2;
    localparam int CNT_W          = 5;

    // Count field saturates at 3 so deep FIFOs still fit in two bits.
    function automatic logic [3:0] status_nibble(
        input logic             empty,
        input logic             full,
        input logic [CNT_W-1:0] count
    );
        logic [1:0] cnt_f;
        cnt_f = (count > CNT_W'(3)) ? 2'd3 : count[1:0];
        return {empty, full, cnt_f};
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with power-of-two depth; storage is not reset,
// readers must qualify head with empty.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/port_feeder.sv
// Feeds host bytes to the DRF CPU port as nibbles, one action per
// CPU port write, with a registered response and sticky overrun flag.
module port_feeder
    import drf_port_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic [3:0] cpu_port_cmd,
    output logic [3:0] cpu_port_data,
    output logic       overrun
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]    cmd_q;
    logic [3:0]    data_d;
    logic          ovr_d;
    logic          accept;
    logic          push;
    logic          pop;
    logic [7:0]    head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (host_data),
        .pop   (pop),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign host_ready = !full;
    assign push       = host_valid && !full;
    assign accept     = (cpu_port_cmd != cmd_q);

    // Empty is the registered flag, so a same-cycle push cannot be read.
    always_comb begin
        data_d = cpu_port_data;
        ovr_d  = overrun;
        pop    = 1'b0;
        if (accept) begin
            case (cpu_port_cmd)
                CMD_RD_HI: begin
                    data_d = empty ? 4'h0 : head[7:4];
                    ovr_d  = overrun | empty;
                end
                CMD_RD_LO_POP: begin
                    data_d = empty ? 4'h0 : head[3:0];
                    ovr_d  = overrun | empty;
                    pop    = !empty;
                end
                CMD_STATUS: begin
                    data_d = status_nibble(empty, full, CNT_W'(count));
                end
                CMD_CLR_ERR: begin
                    data_d = 4'h0;
                    ovr_d  = 1'b0;
                end
                default: begin
                    data_d = cpu_port_data;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q         <= 4'h0;
            cpu_port_data <= 4'h0;
            overrun       <= 1'b0;
        end else begin
            cmd_q         <= cpu_port_cmd;
            cpu_port_data <= data_d;
            overrun       <= ovr_d;
        end
    end

endmodule

// File: tb/tb_port_feeder.sv
// Directed and random checks of port_feeder against a queue-based
// model of the command protocol.
module tb_port_feeder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic [3:0] cpu_port_cmd = 4'h0;
    logic [3:0] cpu_port_data;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q[$];
    logic [3:0] exp_data = 4'h0;
    logic       exp_ovr = 1'b0;
    logic [3:0] prev_cmd = 4'h0;

    port_feeder #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host_data     (host_data),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .cpu_port_cmd  (cpu_port_cmd),
        .cpu_port_data (cpu_port_data),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_status(input int n);
        logic [1:0] f;
        f = (n > 3) ? 2'd3 : 2'(n);
        return {n == 0, n == DEPTH, f};
    endfunction

    // Apply one clock of stimulus, advance the model, compare outputs.
    task automatic step(input logic [3:0] c, input logic v,
                        input logic [7:0] d, input string tag);
        bit was_empty;
        bit was_full;
        bit do_pop;
        cpu_port_cmd = c;
        host_valid   = v;
        host_data    = d;
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        do_pop    = 1'b0;
        @(posedge clk);
        if (c != prev_cmd) begin
            case (c)
                4'h1: begin
                    exp_data = was_empty ? 4'h0 : q[0][7:4];
                    if (was_empty) exp_ovr = 1'b1;
                end
                4'h2: begin
                    exp_data = was_empty ? 4'h0 : q[0][3:0];
                    if (was_empty) exp_ovr = 1'b1;
                    do_pop = !was_empty;
                end
                4'h3: exp_data = m_status(q.size());
                4'hF: begin
                    exp_data = 4'h0;
                    exp_ovr  = 1'b0;
                end
                default: ;
            endcase
        end
        prev_cmd = c;
        if (do_pop) void'(q.pop_front());
        if (v && !was_full) q.push_back(d);
        #1;
        chk({tag, ".data"}, 8'(cpu_port_data), 8'(exp_data));
        chk({tag, ".ovr"}, 8'(overrun), 8'(exp_ovr));
        chk({tag, ".rdy"}, 8'(host_ready), 8'(q.size() != DEPTH));
    endtask

    // Assert reset between edges and check the asynchronous clear.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        host_valid = 1'b0;
        #1;
        chk({tag, ".rst_data"}, 8'(cpu_port_data), 8'h0);
        chk({tag, ".rst_ovr"}, 8'(overrun), 8'h0);
        chk({tag, ".rst_rdy"}, 8'(host_ready), 8'h1);
        q.delete();
        exp_data = 4'h0;
        exp_ovr  = 1'b0;
        prev_cmd = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] cmds [6];
        cmds[0] = 4'h0; cmds[1] = 4'h1; cmds[2] = 4'h2;
        cmds[3] = 4'h3; cmds[4] = 4'hF; cmds[5] = 4'h6;

        do_reset("init");

        // Single byte readout
        step(4'h0, 1'b1, 8'hA5, "a5_push");
        step(4'h1, 1'b0, 8'h00, "a5_hi");
        chk("a5_hi_val", 8'(cpu_port_data), 8'h0A);
        step(4'h2, 1'b0, 8'h00, "a5_lo");
        chk("a5_lo_val", 8'(cpu_port_data), 8'h05);
        step(4'h3, 1'b0, 8'h00, "a5_stat");
        chk("a5_stat_val", 8'(cpu_port_data), 8'h08);

        // Fill to full, fifth byte refused
        step(4'h3, 1'b1, 8'h11, "fill1");
        step(4'h3, 1'b1, 8'h22, "fill2");
        step(4'h3, 1'b1, 8'h33, "fill3");
        step(4'h3, 1'b1, 8'h44, "fill4");
        chk("full_rdy_low", 8'(host_ready), 8'h0);
        step(4'h3, 1'b1, 8'h55, "fill5");
        step(4'h0, 1'b0, 8'h00, "idle");
        step(4'h3, 1'b0, 8'h00, "full_stat");
        chk("full_stat_val", 8'(cpu_port_data), 8'h07);

        // Pop while full with a waiting host byte
        step(4'h2, 1'b1, 8'h99, "full_pop");
        chk("full_pop_val", 8'(cpu_port_data), 8'h01);
        step(4'h2, 1'b1, 8'h99, "refill");
        step(4'h3, 1'b0, 8'h00, "refill_stat");
        chk("refill_stat_val", 8'(cpu_port_data), 8'h07);
        for (int i = 0; i < DEPTH; i++) begin
            step(4'h1, 1'b0, 8'h00, "drain_hi");
            step(4'h2, 1'b0, 8'h00, "drain_lo");
        end
        chk("drain_last", 8'(cpu_port_data), 8'h09);

        // Empty pop, then clear error
        step(4'h0, 1'b0, 8'h00, "e_idle");
        step(4'h2, 1'b0, 8'h00, "e_pop");
        chk("e_pop_ovr", 8'(overrun), 8'h1);
        step(4'hF, 1'b0, 8'h00, "e_clr");
        chk("e_clr_ovr", 8'(overrun), 8'h0);

        // Push into empty with a same-cycle pop
        step(4'h2, 1'b1, 8'h77, "sim_pop");
        chk("sim_pop_ovr", 8'(overrun), 8'h1);
        step(4'h3, 1'b0, 8'h00, "sim_stat");
        chk("sim_stat_val", 8'(cpu_port_data), 8'h01);
        step(4'h2, 1'b0, 8'h00, "sim_drain");
        step(4'hF, 1'b0, 8'h00, "sim_clr");

        // Held commands execute once
        step(4'h0, 1'b1, 8'h12, "h_push1");
        step(4'h0, 1'b1, 8'h34, "h_push2");
        for (int i = 0; i < 10; i++) step(4'h1, 1'b0, 8'h00, "hold_hi");
        chk("hold_hi_val", 8'(cpu_port_data), 8'h01);
        for (int i = 0; i < 10; i++) step(4'h2, 1'b0, 8'h00, "hold_lo");
        chk("hold_lo_val", 8'(cpu_port_data), 8'h02);
        step(4'h1, 1'b0, 8'h00, "hold_next");
        chk("hold_next_val", 8'(cpu_port_data), 8'h03);

        // Reset mid-stream, STATUS present at release
        step(4'h0, 1'b1, 8'hAB, "r_push1");
        step(4'h0, 1'b1, 8'hCD, "r_push2");
        step(4'h0, 1'b1, 8'hEF, "r_push3");
        cpu_port_cmd = 4'h3;
        do_reset("mid");
        step(4'h3, 1'b0, 8'h00, "r_stat");
        chk("r_stat_val", 8'(cpu_port_data), 8'h08);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(cmds[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                 8'($urandom), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
